gen_reg_bank: RTL and testbench
===============================

// Module: gen_reg_bank
// PURPOSE
//  Parametrised bank of general-purpose output registers, written from an external host strobe (WCLK).
//  WCLK is asynchronous to clk. Writes land in shadow registers; COMMIT atomically copies them to the outputs.
//  Optional AUTO_COMMIT mode writes straight through. Registered readback of the shadow registers.
//  Sits between the host write bus and the step/drive logic consuming GEN_OUT.
// PARAMETERS
//  DATA_W       16  width of each register
//  NUM_REGS     4   number of registers (1..16)
//  ADDR_W       2   address width; must be >= clog2(NUM_REGS)
//  SYNC_STAGES  2   synchroniser depth for WCLK and COMMIT (2..3)
//  RESET_VAL    0   reset value of every shadow and active register (DATA_W bits)
//  AUTO_COMMIT  0   1 = writes update shadow and GEN_OUT together, COMMIT ignored
// PORTS
//  clk      in   1                system clock
//  rst_n    in   1                asynchronous reset, active low
//  WE       in   1                write enable, quasi-static, must be stable while WCLK rises
//  WCLK     in   1                async write strobe; a write occurs on its rising edge
//  WADDR    in   ADDR_W           write address, quasi-static like WE
//  WDATA    in   DATA_W           write data, quasi-static like WE
//  COMMIT   in   1                async strobe; its rising edge copies all shadows to GEN_OUT
//  CLR_ERR  in   1                clk-domain level; clears ERR
//  RADDR    in   ADDR_W           readback address (clk domain)
//  RDATA    out  DATA_W           shadow[RADDR], registered
//  GEN_OUT  out  NUM_REGS*DATA_W  active registers; reg i is at [i*DATA_W +: DATA_W]
//  WR_ACK   out  1                one-cycle pulse per accepted write
//  PENDING  out  1                shadow contains writes not yet committed
//  ERR      out  1                sticky: write to address >= NUM_REGS
// BEHAVIOUR
//  - Reset (rst_n low, async): shadow and GEN_OUT = RESET_VAL; RDATA = 0; WR_ACK, PENDING, ERR = 0.
//    Sync flops cleared.
//  - Arming: edges on WCLK and COMMIT are ignored for SYNC_STAGES+1 cycles after reset release.
//    A strobe held high through reset therefore produces no action.
//  - Synchronisation: WCLK and COMMIT each pass through a SYNC_STAGES flop chain.
//    An edge is the synced value AND NOT the previous synced value.
//  - Write latency: WCLK rises before clk edge k. The shadow update, WR_ACK=1 and any ERR set
//    become visible after edge k+SYNC_STAGES. Metastability may add 1 cycle.
//  - Write on a WCLK edge, acting on WE/WADDR/WDATA sampled at that clk edge:
//      WE=0                    -> nothing.
//      WE=1, WADDR<NUM_REGS    -> shadow[WADDR] <= WDATA; WR_ACK pulses 1 cycle;
//                                 PENDING <= 1 (when AUTO_COMMIT=0).
//      WE=1, WADDR>=NUM_REGS   -> write dropped; ERR <= 1; no WR_ACK.
//  - Commit, on a COMMIT edge with AUTO_COMMIT=0: all GEN_OUT words <= shadow in the same cycle.
//    PENDING <= 0. Latency matches writes.
//  - Write edge and commit edge in the same cycle: commit copies the pre-write shadow.
//    The write lands in shadow only, and PENDING stays 1.
//  - AUTO_COMMIT=1: an accepted write updates shadow[WADDR] and GEN_OUT word WADDR in the same cycle.
//    COMMIT is ignored and PENDING stays 0.
//  - ERR: CLR_ERR=1 clears ERR at the next clk edge.
//    If an error write and CLR_ERR coincide, the set wins and ERR stays 1.
//  - RDATA <= shadow[RADDR] at every clk edge (1-cycle latency).
//    RADDR >= NUM_REGS gives 0. A same-cycle write is seen on the following cycle.
//  - Back-to-back writes require WCLK low for at least SYNC_STAGES+1 clk cycles between rising edges.
//    Shorter pulses may be lost; this is not flagged.
//  - GEN_OUT changes only on reset, commit, or an AUTO_COMMIT write.
// TESTING
//  1 Reset: rst_n low with WCLK=1 held, then release.
//    -> GEN_OUT=all RESET_VAL, PENDING=0, WR_ACK never pulses over 10 cycles.
//  2 Shadow write: WE=1, WADDR=1, WDATA=16'hA3A3, raise WCLK.
//    -> WR_ACK pulse after SYNC_STAGES(+1) cycles; RDATA(RADDR=1)=A3A3; PENDING=1; GEN_OUT word1 still 0.
//  3 Commit: write regs 0..3 = 1111/2222/3333/4444, then pulse COMMIT.
//    -> all four words change in one cycle; PENDING=0.
//  4 Collision: shadow0=1111 committed; write 5555 to reg0 with COMMIT edge in the same cycle.
//    -> GEN_OUT word0=1111, shadow0=5555, PENDING=1.
//  5 Error (NUM_REGS=3, ADDR_W=2): write WADDR=3.
//    -> ERR=1, no WR_ACK, shadows unchanged. CLR_ERR=1 for 1 cycle -> ERR=0.
//  6 AUTO_COMMIT=1: write reg2=BEEF.
//    -> GEN_OUT word2=BEEF with WR_ACK; COMMIT pulse has no effect; PENDING=0 throughout.

Source files
------------

// File: rtl/gen_reg_bank.sv
// gen_reg_bank: bank of general-purpose output registers written from an
// asynchronous host strobe (WCLK). Writes land in shadow registers and a
// COMMIT strobe copies every shadow to GEN_OUT in one cycle; AUTO_COMMIT
// makes writes go straight through. Shadow contents are read back on RDATA.
module gen_reg_bank #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       NUM_REGS    = 4,
  parameter int unsigned       ADDR_W      = 2,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0,
  parameter bit                AUTO_COMMIT = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         WE,
  input  logic                         WCLK,
  input  logic [ADDR_W-1:0]            WADDR,
  input  logic [DATA_W-1:0]            WDATA,
  input  logic                         COMMIT,
  input  logic                         CLR_ERR,
  input  logic [ADDR_W-1:0]            RADDR,
  output logic [DATA_W-1:0]            RDATA,
  output logic [NUM_REGS*DATA_W-1:0]   GEN_OUT,
  output logic                         WR_ACK,
  output logic                         PENDING,
  output logic                         ERR
);

  localparam int unsigned     ARM_CYCLES  = SYNC_STAGES + 1;
  localparam int unsigned     ARM_W       = $clog2(ARM_CYCLES + 1);
  localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

  logic [ARM_W-1:0]       r_arm_cnt;
  logic [SYNC_STAGES-1:0] r_wclk_sync;
  logic [SYNC_STAGES-1:0] r_commit_sync;
  logic                   r_wclk_prev;
  logic                   r_commit_prev;
  logic [DATA_W-1:0]      r_shadow [NUM_REGS];
  logic [DATA_W-1:0]      r_active [NUM_REGS];
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_wr_ack;
  logic                   r_pending;
  logic                   r_err;

  logic                   w_armed;
  logic                   w_wr_edge;
  logic                   w_cm_edge;
  logic                   w_addr_ok;
  logic                   w_wr_accept;
  logic                   w_wr_error;
  logic [DATA_W-1:0]      w_rd_word;

  // Arming counter: strobe edges are ignored until it saturates after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYCLES));

  // Synchronise WCLK and COMMIT and keep the previous synced level for edge detection.
  // The previous-level flops track even while unarmed, so a strobe held high
  // across reset release never looks like a fresh edge once armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wclk_sync   <= '0;
      r_commit_sync <= '0;
      r_wclk_prev   <= 1'b0;
      r_commit_prev <= 1'b0;
    end else begin
      r_wclk_sync   <= {r_wclk_sync[SYNC_STAGES-2:0], WCLK};
      r_commit_sync <= {r_commit_sync[SYNC_STAGES-2:0], COMMIT};
      r_wclk_prev   <= r_wclk_sync[SYNC_STAGES-1];
      r_commit_prev <= r_commit_sync[SYNC_STAGES-1];
    end
  end

  assign w_wr_edge   = w_armed & r_wclk_sync[SYNC_STAGES-1] & ~r_wclk_prev;
  assign w_cm_edge   = w_armed & r_commit_sync[SYNC_STAGES-1] & ~r_commit_prev
                       & (AUTO_COMMIT == 1'b0);
  assign w_addr_ok   = ({1'b0, WADDR} < LP_NUM_REGS);
  assign w_wr_accept = w_wr_edge & WE & w_addr_ok;
  assign w_wr_error  = w_wr_edge & WE & ~w_addr_ok;

  // Shadow registers: updated by every accepted host write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= RESET_VAL;
      end
    end else if (w_wr_accept) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (WADDR == ADDR_W'(i)) begin
          r_shadow[i] <= WDATA;
        end
      end
    end
  end

  // Active registers: written through in auto mode, otherwise bulk-copied on commit.
  // A commit coinciding with a write copies the shadow as it was before that write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_active[i] <= RESET_VAL;
      end
    end else if (AUTO_COMMIT) begin
      if (w_wr_accept) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (WADDR == ADDR_W'(i)) begin
            r_active[i] <= WDATA;
          end
        end
      end
    end else if (w_cm_edge) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_active[i] <= r_shadow[i];
      end
    end
  end

  // Status flags: write acknowledge, uncommitted-data flag and sticky address error.
  // A write in the commit cycle keeps PENDING set; an error write beats CLR_ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ack  <= 1'b0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_accept;
      if (AUTO_COMMIT) begin
        r_pending <= 1'b0;
      end else if (w_wr_accept) begin
        r_pending <= 1'b1;
      end else if (w_cm_edge) begin
        r_pending <= 1'b0;
      end
      if (w_wr_error) begin
        r_err <= 1'b1;
      end else if (CLR_ERR) begin
        r_err <= 1'b0;
      end
    end
  end

  // Readback mux: addresses beyond the bank read as zero.
  always_comb begin
    w_rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (RADDR == ADDR_W'(i)) begin
        w_rd_word = r_shadow[i];
      end
    end
  end

  // Registered readback of the selected shadow word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd_word;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign GEN_OUT[g*DATA_W +: DATA_W] = r_active[g];
    end
  endgenerate

  assign RDATA   = r_rdata;
  assign WR_ACK  = r_wr_ack;
  assign PENDING = r_pending;
  assign ERR     = r_err;

endmodule

// File: tb/tb_gen_reg_bank.sv
// Directed bench for gen_reg_bank: three instances (deferred commit, 3-register
// bank with error address, auto-commit) driven from one linear sequence.
module tb_gen_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic        clr_err;
  logic [1:0]  waddr;
  logic [1:0]  raddr;
  logic [15:0] wdata;
  logic        wclk_a, wclk_e, wclk_c;
  logic        commit_a, commit_e, commit_c;

  logic [15:0] rdata_a, rdata_e, rdata_c;
  logic [63:0] gen_a, gen_c;
  logic [47:0] gen_e;
  logic        ack_a, ack_e, ack_c;
  logic        pend_a, pend_e, pend_c;
  logic        err_a, err_e, err_c;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] g_pre, g_ack;
  logic        p_ack, e_ack;

  always #5 clk = ~clk;

  gen_reg_bank #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(2), .SYNC_STAGES(2),
                 .RESET_VAL(16'h0000), .AUTO_COMMIT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .WE(we), .WCLK(wclk_a), .WADDR(waddr), .WDATA(wdata),
    .COMMIT(commit_a), .CLR_ERR(clr_err), .RADDR(raddr), .RDATA(rdata_a),
    .GEN_OUT(gen_a), .WR_ACK(ack_a), .PENDING(pend_a), .ERR(err_a));

  gen_reg_bank #(.DATA_W(16), .NUM_REGS(3), .ADDR_W(2), .SYNC_STAGES(2),
                 .RESET_VAL(16'h00F0), .AUTO_COMMIT(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .WE(we), .WCLK(wclk_e), .WADDR(waddr), .WDATA(wdata),
    .COMMIT(commit_e), .CLR_ERR(clr_err), .RADDR(raddr), .RDATA(rdata_e),
    .GEN_OUT(gen_e), .WR_ACK(ack_e), .PENDING(pend_e), .ERR(err_e));

  gen_reg_bank #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(2), .SYNC_STAGES(2),
                 .RESET_VAL(16'h0000), .AUTO_COMMIT(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .WE(we), .WCLK(wclk_c), .WADDR(waddr), .WDATA(wdata),
    .COMMIT(commit_c), .CLR_ERR(clr_err), .RADDR(raddr), .RDATA(rdata_c),
    .GEN_OUT(gen_c), .WR_ACK(ack_c), .PENDING(pend_c), .ERR(err_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d == 0) ? ack_a : (d == 1) ? ack_e : ack_c;
  endfunction

  function automatic logic pend_of(input int d);
    return (d == 0) ? pend_a : (d == 1) ? pend_e : pend_c;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? err_a : (d == 1) ? err_e : err_c;
  endfunction

  function automatic logic [63:0] gen_of(input int d);
    return (d == 0) ? gen_a : (d == 1) ? {16'h0000, gen_e} : gen_c;
  endfunction

  task automatic set_wclk(input int d, input logic v);
    case (d)
      0:       wclk_a = v;
      1:       wclk_e = v;
      default: wclk_c = v;
    endcase
  endtask

  task automatic set_commit(input int d, input logic v);
    case (d)
      0:       commit_a = v;
      1:       commit_e = v;
      default: commit_c = v;
    endcase
  endtask

  // One host write; WR_ACK expected exactly two edges after the first edge seeing WCLK high.
  task automatic wr(input int d, input logic [1:0] a, input logic [15:0] v,
                    input logic exp_ack, input string tag);
    we = 1'b1; waddr = a; wdata = v;
    set_wclk(d, 1'b1);
    tick(); check({tag, "_ack_k"},  {63'h0, ack_of(d)}, 64'h0);
    tick(); check({tag, "_ack_k1"}, {63'h0, ack_of(d)}, 64'h0);
    g_pre = gen_of(d);
    tick(); check({tag, "_ack_k2"}, {63'h0, ack_of(d)}, {63'h0, exp_ack});
    g_ack = gen_of(d);
    p_ack = pend_of(d);
    e_ack = err_of(d);
    set_wclk(d, 1'b0);
    tick(); check({tag, "_ack_end"}, {63'h0, ack_of(d)}, 64'h0);
    tick(); tick();
    we = 1'b0;
  endtask

  task automatic cm(input int d);
    set_commit(d, 1'b1);
    repeat (3) tick();
    set_commit(d, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with strobes held high and an active write presented
    rst_n = 1'b0; we = 1'b1; waddr = 2'd3; wdata = 16'hDEAD; raddr = 2'd0; clr_err = 1'b0;
    wclk_a = 1'b1; wclk_e = 1'b1; wclk_c = 1'b1;
    commit_a = 1'b1; commit_e = 1'b1; commit_c = 1'b1;
    repeat (3) tick();
    check("rst_gen_a", gen_a, 64'h0);
    check("rst_gen_e", {16'h0, gen_e}, 64'h0000_00F0_00F0_00F0);
    check("rst_flags_a", {61'h0, ack_a, pend_a, err_a}, 64'h0);
    check("rst_rdata_e", {48'h0, rdata_e}, 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("arm_no_ack_err", {60'h0, ack_a, ack_e, ack_c, err_e}, 64'h0);
    end
    check("arm_gen_a", gen_a, 64'h0);
    check("arm_gen_c", gen_c, 64'h0);
    check("arm_pend", {62'h0, pend_a, pend_e}, 64'h0);
    wclk_a = 1'b0; wclk_e = 1'b0; wclk_c = 1'b0;
    commit_a = 1'b0; commit_e = 1'b0; commit_c = 1'b0; we = 1'b0;
    repeat (4) tick();

    // 2: shadow-only write
    raddr = 2'd1;
    wr(0, 2'd1, 16'hA3A3, 1'b1, "t2");
    check("t2_rdata", {48'h0, rdata_a}, 64'h0000_0000_0000_A3A3);
    check("t2_pend", {63'h0, pend_a}, 64'h1);
    check("t2_gen", gen_a, 64'h0);

    // 3: fill all four shadows then commit atomically
    wr(0, 2'd0, 16'h1111, 1'b1, "t3_w0");
    wr(0, 2'd1, 16'h2222, 1'b1, "t3_w1");
    wr(0, 2'd2, 16'h3333, 1'b1, "t3_w2");
    wr(0, 2'd3, 16'h4444, 1'b1, "t3_w3");
    check("t3_pre_gen", gen_a, 64'h0);
    check("t3_pre_pend", {63'h0, pend_a}, 64'h1);
    commit_a = 1'b1;
    tick(); check("t3_gen_k", gen_a, 64'h0);
    tick(); check("t3_gen_k1", gen_a, 64'h0);
    tick(); check("t3_gen_k2", gen_a, 64'h4444_3333_2222_1111);
    check("t3_pend", {63'h0, pend_a}, 64'h0);
    commit_a = 1'b0;
    repeat (3) tick();
    raddr = 2'd3;
    tick();
    check("t3_rdata3", {48'h0, rdata_a}, 64'h0000_0000_0000_4444);

    // 4: write and commit edges in the same cycle
    we = 1'b1; waddr = 2'd0; wdata = 16'h5555; raddr = 2'd0;
    wclk_a = 1'b1; commit_a = 1'b1;
    repeat (3) tick();
    check("t4_ack", {63'h0, ack_a}, 64'h1);
    check("t4_gen", gen_a, 64'h4444_3333_2222_1111);
    check("t4_pend", {63'h0, pend_a}, 64'h1);
    wclk_a = 1'b0; commit_a = 1'b0;
    repeat (3) tick();
    we = 1'b0;
    check("t4_rdata0", {48'h0, rdata_a}, 64'h0000_0000_0000_5555);
    check("t4_gen_hold", gen_a, 64'h4444_3333_2222_1111);
    cm(0);
    check("t4_gen_commit", gen_a, 64'h4444_3333_2222_5555);
    check("t4_pend_commit", {63'h0, pend_a}, 64'h0);

    // 5: 3-register bank, out-of-range write and error clearing
    wr(1, 2'd2, 16'h7777, 1'b1, "t5_w2");
    check("t5_pend", {63'h0, pend_e}, 64'h1);
    wr(1, 2'd3, 16'hBAD0, 1'b0, "t5_err");
    check("t5_err_set", {63'h0, err_e}, 64'h1);
    raddr = 2'd2; tick(); tick();
    check("t5_rd2", {48'h0, rdata_e}, 64'h0000_0000_0000_7777);
    raddr = 2'd3; tick(); tick();
    check("t5_rd3_oor", {48'h0, rdata_e}, 64'h0);
    raddr = 2'd0; tick(); tick();
    check("t5_rd0", {48'h0, rdata_e}, 64'h0000_0000_0000_00F0);
    check("t5_gen", {16'h0, gen_e}, 64'h0000_00F0_00F0_00F0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("t5_err_clr", {63'h0, err_e}, 64'h0);
    tick();
    check("t5_err_stays_clr", {63'h0, err_e}, 64'h0);
    clr_err = 1'b1;
    wr(1, 2'd3, 16'hBAD1, 1'b0, "t5_err2");
    check("t5_set_wins", {63'h0, e_ack}, 64'h1);
    check("t5_err_after_clr", {63'h0, err_e}, 64'h0);
    clr_err = 1'b0;

    // 6: auto-commit instance
    raddr = 2'd2;
    wr(2, 2'd2, 16'hBEEF, 1'b1, "t6");
    check("t6_gen_before_ack", g_pre, 64'h0);
    check("t6_gen_with_ack", g_ack, 64'h0000_BEEF_0000_0000);
    check("t6_pend_with_ack", {63'h0, p_ack}, 64'h0);
    check("t6_rdata", {48'h0, rdata_c}, 64'h0000_0000_0000_BEEF);
    cm(2);
    check("t6_gen_after_commit", gen_c, 64'h0000_BEEF_0000_0000);
    check("t6_pend_after_commit", {63'h0, pend_c}, 64'h0);
    check("t6_gen_a_untouched", gen_a, 64'h4444_3333_2222_5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
